// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall/flush, tnew countdown and stall-timeout debug.
// Optional PIPE_STAGE_STAT_EN adds free-running bubble/stall event counters.
module pipe_stage_reg #(
  parameter int DATA_W        = 160,
  parameter int ADDR_W        = 5,
  parameter int TNEW_W        = 2,
  parameter int CNT_W         = 8,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              rf_we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [TNEW_W-1:0] tnew_i,
  input  logic [DATA_W-1:0] payload_i,
  output logic              valid_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [DATA_W-1:0] payload_o,
  output logic [CNT_W-1:0]  hold_cnt_o,
  output logic              stall_timeout_o
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(STALL_TIMEOUT);
  logic              hold;
  logic              bubble;
  logic [CNT_W-1:0]  hold_cnt_nxt;
  logic [TNEW_W-1:0] tnew_nxt;
  // flush wins over stall; an invalid load is indistinguishable from a flush
  always_comb begin
    hold         = !flush_i && stall_i;
    bubble       = flush_i || (!stall_i && !valid_i);
    hold_cnt_nxt = hold ? ((hold_cnt_o == CNT_MAX) ? hold_cnt_o : hold_cnt_o + CNT_W'(1)) : '0;
    tnew_nxt     = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_o         <= 1'b0;
      rf_we_o         <= 1'b0;
      waddr_o         <= '0;
      tnew_o          <= '0;
      payload_o       <= '0;
      hold_cnt_o      <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      hold_cnt_o      <= hold_cnt_nxt;
      stall_timeout_o <= hold_cnt_nxt >= TIMEOUT;
      if (bubble) begin
        valid_o   <= 1'b0;
        rf_we_o   <= 1'b0;
        waddr_o   <= '0;
        tnew_o    <= '0;
        payload_o <= '0;
      end else if (!hold) begin
        valid_o   <= 1'b1;
        rf_we_o   <= rf_we_i;
        waddr_o   <= waddr_i;
        tnew_o    <= tnew_nxt;
        payload_o <= payload_i;
      end
    end
`ifdef PIPE_STAGE_STAT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bubble_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      bubble_cnt_o <= bubble_cnt_o + 32'(bubble);
      stall_cnt_o  <= stall_cnt_o + 32'(hold);
    end
`endif
endmodule
